// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Purpose  : Memory/write-back pipeline register for the MIPS datapath.
//             Captures the retiring instruction, resolves the destination
//             register and write-back value, and presents an instruction
//             word whose bits [15:11] always carry the final destination.
//             Valid/ready handshake on both sides, one-cycle flush, and a
//             retired-instruction counter.
//  Ports    : clk, rst_n (sync active-low)
//             in_valid/in_ready  : upstream handshake
//             instru, pc, alu_result, mem_rdata : retiring instruction data
//             flush              : drop held entry and this cycle's input
//             out_valid/out_ready: downstream handshake
//             wb_instru, wb_data, wb_addr, wb_en : resolved write-back
//             retired            : count of completed output handshakes
//  Config   : LOAD_SUBWORD_EN - adds lb/lbu/lh/lhu (big-endian lanes).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instru,
    input  logic [31:0] pc,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wb_instru,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_addr,
    output logic        wb_en,
    output logic [31:0] retired
);

    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
    localparam logic [5:0] c_OP_JAL     = 6'b000011;
    localparam logic [5:0] c_OP_LW      = 6'b100011;
    localparam logic [5:0] c_FN_JR      = 6'b001000;
    localparam logic [5:0] c_FN_JALR    = 6'b001001;
`ifdef LOAD_SUBWORD_EN
    localparam logic [5:0] c_OP_LB      = 6'b100000;
    localparam logic [5:0] c_OP_LBU     = 6'b100100;
    localparam logic [5:0] c_OP_LH      = 6'b100001;
    localparam logic [5:0] c_OP_LHU     = 6'b100101;
`endif

    // Registered state
    logic        out_valid_q, out_valid_d;
    logic [31:0] wb_instru_q, wb_instru_d;
    logic [31:0] wb_data_q,   wb_data_d;
    logic [4:0]  wb_addr_q,   wb_addr_d;
    logic        wb_en_q,     wb_en_d;
    logic [31:0] retired_q,   retired_d;

    // Decode results for the instruction currently on the input
    logic [4:0]  w_dest;
    logic [31:0] w_data;
    logic        w_writes;
    logic [31:0] w_link;
    logic        w_capture;
    logic        w_release;

`ifdef LOAD_SUBWORD_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Big-endian: byte 0 is the most significant lane of the word.
    always_comb begin
        w_byte = 8'h00;
        case (alu_result[1:0])
            2'd0:    w_byte = mem_rdata[31:24];
            2'd1:    w_byte = mem_rdata[23:16];
            2'd2:    w_byte = mem_rdata[15:8];
            default: w_byte = mem_rdata[7:0];
        endcase
        // alu_result[0] is deliberately ignored for halfword accesses.
        w_half = alu_result[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    end
`endif

    assign w_link = pc + 32'd8;  // wraps naturally modulo 2^32

    always_comb begin
        w_dest   = 5'd0;
        w_data   = 32'd0;
        w_writes = 1'b0;
        casez (instru[31:26])
            c_OP_SPECIAL: begin
                if (instru[5:0] == c_FN_JR) begin
                    w_writes = 1'b0;
                end else if (instru[5:0] == c_FN_JALR) begin
                    w_dest   = instru[15:11];
                    w_data   = w_link;
                    w_writes = 1'b1;
                end else begin
                    w_dest   = instru[15:11];
                    w_data   = alu_result;
                    w_writes = 1'b1;
                end
            end
            c_OP_JAL: begin
                w_dest   = 5'd31;
                w_data   = w_link;
                w_writes = 1'b1;
            end
            c_OP_LW: begin
                w_dest   = instru[20:16];
                w_data   = mem_rdata;
                w_writes = 1'b1;
            end
            6'b001???: begin  // addi .. lui
                w_dest   = instru[20:16];
                w_data   = alu_result;
                w_writes = 1'b1;
            end
`ifdef LOAD_SUBWORD_EN
            c_OP_LB: begin
                w_dest   = instru[20:16];
                w_data   = {{24{w_byte[7]}}, w_byte};
                w_writes = 1'b1;
            end
            c_OP_LBU: begin
                w_dest   = instru[20:16];
                w_data   = {24'd0, w_byte};
                w_writes = 1'b1;
            end
            c_OP_LH: begin
                w_dest   = instru[20:16];
                w_data   = {{16{w_half[15]}}, w_half};
                w_writes = 1'b1;
            end
            c_OP_LHU: begin
                w_dest   = instru[20:16];
                w_data   = {16'd0, w_half};
                w_writes = 1'b1;
            end
`endif
            default: begin
                w_dest   = 5'd0;
                w_data   = 32'd0;
                w_writes = 1'b0;
            end
        endcase
    end

    assign in_ready  = !out_valid_q || out_ready;
    assign w_capture = in_valid && in_ready && !flush;
    // A flushed entry never counts as retired, even if out_ready is high.
    assign w_release = out_valid_q && out_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        wb_instru_d = wb_instru_q;
        wb_data_d   = wb_data_q;
        wb_addr_d   = wb_addr_q;
        wb_en_d     = wb_en_q;
        retired_d   = retired_q + {31'd0, w_release};

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_capture) begin
            out_valid_d = 1'b1;
            wb_instru_d = {instru[31:16], w_dest, instru[10:0]};
            wb_data_d   = w_data;
            wb_addr_d   = w_dest;
            // Writes to $zero are suppressed; the data is still kept.
            wb_en_d     = w_writes && (w_dest != 5'd0);
        end else if (w_release) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            wb_instru_q <= 32'd0;
            wb_data_q   <= 32'd0;
            wb_addr_q   <= 5'd0;
            wb_en_q     <= 1'b0;
            retired_q   <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            wb_instru_q <= wb_instru_d;
            wb_data_q   <= wb_data_d;
            wb_addr_q   <= wb_addr_d;
            wb_en_q     <= wb_en_d;
            retired_q   <= retired_d;
        end
    end

    assign out_valid = out_valid_q;
    assign wb_instru = wb_instru_q;
    assign wb_data   = wb_data_q;
    assign wb_addr   = wb_addr_q;
    assign wb_en     = wb_en_q;
    assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Purpose  : Directed self-checking bench for mem_wb_stage. Walks through
//             reset, each decode class, backpressure, flush, pc+8 wrap and
//             reset of a held entry, with hand-computed expected values.
//  Config   : LOAD_SUBWORD_EN - selects subword-load expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instru;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_instru;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_en;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    // Expected state of the entry currently held by the stage
    logic [31:0] exp_instru;
    logic [31:0] exp_data;
    logic [4:0]  exp_addr;
    logic        exp_en;
    logic [31:0] exp_retired;

    mem_wb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instru     (instru),
        .pc         (pc),
        .alu_result (alu_result),
        .mem_rdata  (mem_rdata),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wb_instru  (wb_instru),
        .wb_data    (wb_data),
        .wb_addr    (wb_addr),
        .wb_en      (wb_en),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_entry(input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".wb_addr"},   {27'd0, wb_addr},   {27'd0, exp_addr});
        check({tag, ".wb_data"},   wb_data,            exp_data);
        check({tag, ".wb_en"},     {31'd0, wb_en},     {31'd0, exp_en});
        check({tag, ".wb_instru"}, wb_instru,          exp_instru);
        check({tag, ".retired"},   retired,            exp_retired);
    endtask

    // Present one instruction with out_ready high, clock it in, then check.
    // Any entry already held drains on the same edge.
    task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] e_addr, input logic [31:0] e_data,
                         input logic e_en, input logic [31:0] e_instru);
        instru     = ins;
        pc         = p;
        alu_result = alu;
        mem_rdata  = rd;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        if (out_valid) exp_retired = exp_retired + 32'd1;
        step();
        exp_addr   = e_addr;
        exp_data   = e_data;
        exp_en     = e_en;
        exp_instru = e_instru;
        check_entry(tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        instru     = 32'd0;
        pc         = 32'd0;
        alu_result = 32'd0;
        mem_rdata  = 32'd0;
        exp_retired = 32'd0;

        // Reset
        step();
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.retired",   retired,            32'd0);
        check("rst.wb_instru", wb_instru,          32'd0);
        check("rst.wb_data",   wb_data,            32'd0);
        check("rst.wb_en",     {31'd0, wb_en},     32'd0);
        check("rst.in_ready",  {31'd0, in_ready},  32'd1);
        rst_n = 1'b1;

        // Decode classes, back-to-back at full throughput
        issue("add",  32'h00224820, 32'h00400000, 32'h12345678, 32'h0,
              5'd9,  32'h12345678, 1'b1, 32'h00224820);
        issue("jal",  32'h0C100004, 32'h00400010, 32'h0, 32'h0,
              5'd31, 32'h00400018, 1'b1, 32'h0C10F804);
        issue("lw",   32'h8C900008, 32'h00400014, 32'h00001008, 32'hCAFEBABE,
              5'd16, 32'hCAFEBABE, 1'b1, 32'h8C908008);
        issue("jr",   32'h03E00008, 32'h00400018, 32'h0, 32'h0,
              5'd0,  32'h0,        1'b0, 32'h03E00008);
        issue("addi0", 32'h20200005, 32'h0040001C, 32'h00000077, 32'h0,
              5'd0,  32'h00000077, 1'b0, 32'h20200005);
        issue("sw",   32'hAC050000, 32'h00400020, 32'h00001000, 32'h0,
              5'd0,  32'h0,        1'b0, 32'hAC050000);
`ifdef LOAD_SUBWORD_EN
        issue("lb",   32'h80070000, 32'h00400024, 32'h00001000, 32'h80FF7F01,
              5'd7,  32'hFFFFFF80, 1'b1, 32'h80073800);
        issue("lbu",  32'h90080000, 32'h00400028, 32'h00001001, 32'h80FF7F01,
              5'd8,  32'h000000FF, 1'b1, 32'h90084000);
        issue("lh",   32'h84090000, 32'h0040002C, 32'h00001002, 32'h80FF7F01,
              5'd9,  32'h00007F01, 1'b1, 32'h84094800);
        issue("lhu",  32'h940A0000, 32'h00400030, 32'h00001000, 32'h80FF7F01,
              5'd10, 32'h000080FF, 1'b1, 32'h940A5000);
`else
        issue("lb",   32'h80070000, 32'h00400024, 32'h00001000, 32'h80FF7F01,
              5'd0,  32'h0,        1'b0, 32'h80070000);
`endif

        // Backpressure: new instruction waits while the held entry stalls
        instru     = 32'h00221821;
        alu_result = 32'hAAAA5555;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        #1;
        check("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_entry("bp.hold");
            check("bp.in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_high", {31'd0, in_ready}, 32'd1);
        exp_retired = exp_retired + 32'd1;
        step();
        exp_addr   = 5'd3;
        exp_data   = 32'hAAAA5555;
        exp_en     = 1'b1;
        exp_instru = 32'h00221821;
        check_entry("bp.drain");

        // Flush with an entry held, out_ready high, and a new input present
        instru     = 32'h24040001;
        alu_result = 32'h00000099;
        flush      = 1'b1;
        step();
        check("flush.out_valid", {31'd0, out_valid}, 32'd0);
        check("flush.retired",   retired,            exp_retired);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush.dropped",   {31'd0, out_valid}, 32'd0);
        check("flush.retired2",  retired,            exp_retired);

        // jalr: pc+8 wraps around 2^32
        issue("jalr_wrap", 32'h00402809, 32'hFFFFFFFC, 32'h0, 32'h0,
              5'd5, 32'h00000004, 1'b1, 32'h00402809);
        in_valid = 1'b0;
        exp_retired = exp_retired + 32'd1;
        step();
        check("drain.out_valid", {31'd0, out_valid}, 32'd0);
        check("drain.retired",   retired,            exp_retired);

        // Reset with an entry held discards it and clears the counter
        issue("pre_rst", 32'h00224820, 32'h0, 32'h0000BEEF, 32'h0,
              5'd9, 32'h0000BEEF, 1'b1, 32'h00224820);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        check("rst2.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst2.wb_data",   wb_data,            32'd0);
        check("rst2.wb_addr",   {27'd0, wb_addr},   32'd0);
        check("rst2.wb_en",     {31'd0, wb_en},     32'd0);
        check("rst2.wb_instru", wb_instru,          32'd0);
        check("rst2.retired",   retired,            32'd0);
        check("rst2.in_ready",  {31'd0, in_ready},  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/write-back pipeline register for the MIPS datapath. Sits directly upstream of the register write block: captures the retiring instruction with its ALU result, load data and PC, resolves the destination register and write-back value, and presents an instruction word whose bits [15:11] always hold the final destination. A valid/ready handshake is used on both sides, with a one-cycle flush and a retired-instruction counter.

## Interface
- No parameters; all widths fixed at 32-bit datapath, 5-bit register index.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; combinational: !out_valid || out_ready
- instru  in  32  retiring instruction word
- pc  in  32  PC of that instruction
- alu_result  in  32  ALU result / load effective address
- mem_rdata  in  32  aligned word read from data memory
- flush  in  1  discard held entry and input this cycle
- out_valid  out  1  wb_* fields valid
- out_ready  in  1  downstream consumes entry
- wb_instru  out  32  instru with [15:11] replaced by resolved destination
- wb_data  out  32  value to write
- wb_addr  out  5  resolved destination (equals wb_instru[15:11])
- wb_en  out  1  write required (0 for non-writing ops and for $zero)
- retired  out  32  count of completed output handshakes

## Operation
- Capture: on in_valid && in_ready && !flush, register all wb_* fields; out_valid <= 1.
- Release: out_valid && out_ready without capture -> out_valid <= 0; with capture, new entry replaces old (back-to-back throughput 1/cycle).
- Flush: out_valid <= 0, input ignored; flush has priority over capture and release; retired not incremented for a flushed entry even if out_ready high.
- Decode on instru[31:26] (op), [5:0] (funct):
  - op 000000, funct 001000 (jr): wb_en=0.
  - op 000000, funct 001001 (jalr): dest rd [15:11], data pc+8.
  - op 000000 other: dest rd, data alu_result.
  - op 000011 (jal): dest 5'b11111, data pc+8.
  - op 100011 (lw): dest rt [20:16], data mem_rdata.
  - op 001000–001111 (addi..lui): dest rt, data alu_result.
  - all other ops: wb_en=0, wb_addr=0, wb_data=0.
- Resolved dest 0 -> wb_en=0 (data still registered).
- pc+8 computed modulo 2^32.
- wb_instru = {instru[31:16], wb_addr, instru[10:0]}.
- retired increments on out_valid && out_ready && !flush; wraps 0xFFFFFFFF -> 0.

## Timing
- Latency 1 cycle: input accepted at edge N is on wb_* after edge N.
- wb_* held stable while out_valid && !out_ready.
- Reset (rst_n low at edge): out_valid, wb_en, wb_addr, wb_data, wb_instru, retired all 0; in_ready therefore 1. Reset mid-entry discards it.
- in_ready purely combinational from out_valid/out_ready; no combinational path from in_valid to outputs.

## Configuration
- LOAD_SUBWORD_EN defined: op 100000 lb, 100100 lbu, 100001 lh, 100101 lhu write rt. Big-endian: byte k = alu_result[1:0] selects mem_rdata[31-8k -: 8]; half selects [31:16] when alu_result[1]=0 else [15:0]; lb/lh sign-extend, lbu/lhu zero-extend. alu_result[0] ignored for halves.
- Undefined: those opcodes fall into "other", wb_en=0.

## Test plan
- Reset: rst_n=0 one cycle -> out_valid=0, retired=0, wb_instru=0, in_ready=1.
- R-type add rd=9, alu_result=0x12345678, out_ready=1 -> next cycle wb_addr=9, wb_data=0x12345678, wb_en=1, wb_instru[15:11]=01001, retired=1 one cycle later.
- jal at pc=0x00400010 -> wb_addr=31, wb_data=0x00400018; lw rt=16, mem_rdata=0xCAFEBABE -> wb_addr=16, wb_data=0xCAFEBABE; jr -> wb_en=0; addi rt=0 -> wb_en=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, wb_* unchanged, retired unchanged; out_ready=1 -> held entry drains, next accepted same edge.
- Flush with entry held and out_ready=1 -> out_valid=0 next cycle, retired not incremented; simultaneous in_valid entry dropped.
- LOAD_SUBWORD_EN: mem_rdata=0x80FF7F01, lb addr[1:0]=0 -> 0xFFFFFF80; lbu addr 1 -> 0x000000FF; lh addr 2 -> 0x00007F01; lhu addr 0 -> 0x000080FF. Without macro: lb -> wb_en=0.
